core_mem_arbiter: RTL and testbench

//  Parametrised successor to the core instruction/data memory controller.

---
 rtl/core_mem_arbiter_pkg.sv | 23 ++
 rtl/core_mem_arbiter_lat_counter.sv | 34 +++
 rtl/core_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_core_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter: FSM state encoding,
// address section bits and the latency-counter width.
package core_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IRD,
        ST_DRD,
        ST_DSRD,
        ST_DWR
    } state_e;

    localparam logic SEC_INSTR = 1'b0;
    localparam logic SEC_DATA  = 1'b1;

    localparam int LAT_MAX   = 16;
    localparam int LAT_CNT_W = $clog2(LAT_MAX);

    function automatic logic is_data_state(state_e s);
        return (s == ST_DRD) || (s == ST_DSRD) || (s == ST_DWR);
    endfunction

endpackage

// File: rtl/core_mem_arbiter_lat_counter.sv
// Loadable down-counter timing one bus access phase; last_o flags the final
// cycle of the phase (count 0). Idles at 0 when not loaded.
module cmc_lat_counter
    import core_mem_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] val_i,
    output logic                 last_o
);

    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/core_mem_arbiter.sv
// Fetch/data memory arbiter onto a unified tristate bus with MEM_LAT-cycle phases.
// Define CORE_MEM_ARB_RR_EN for round-robin ties; otherwise data always wins ties.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_iReq,
    input  logic [ADDR_W-1:0] i_iAddr,
    output logic              o_iAck,
    output logic [DATA_W-1:0] o_iRdData,
    input  logic              i_dReq,
    input  logic [ADDR_W-1:0] i_dAddr,
    input  logic              i_dWr,
    input  logic              i_dSwp,
    input  logic [DATA_W-1:0] i_dWrData,
    output logic              o_dAck,
    output logic [DATA_W-1:0] o_dRdData,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_memAddr,
    inout  wire  [DATA_W-1:0] io_memData,
    output logic              o_memWr
);

    localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic              iack_q, dack_q;
    logic [DATA_W-1:0] irdata_q, drdata_q;
    logic [DATA_W-1:0] wbuf_q;
    logic              cnt_load, cnt_last;
    logic              arb_pt, i_elig, d_elig, gnt_i, gnt_d, pri_d;

`ifdef CORE_MEM_ARB_RR_EN
    logic last_d_q;
    assign pri_d = ~last_d_q;
`else
    assign pri_d = 1'b1;
`endif

    // A channel whose ack is showing this cycle has already been served.
    assign arb_pt = (state_q == ST_IDLE) ||
                    (cnt_last && (state_q == ST_IRD || state_q == ST_DRD || state_q == ST_DWR));
    assign i_elig = i_iReq && !iack_q;
    assign d_elig = i_dReq && !dack_q;
    assign gnt_d  = arb_pt && d_elig && (!i_elig || pri_d);
    assign gnt_i  = arb_pt && i_elig && !gnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        if (gnt_d) begin
            cnt_load = 1'b1;
            if (i_dSwp) begin
                state_d = ST_DSRD;
            end else if (i_dWr) begin
                state_d = ST_DWR;
            end else begin
                state_d = ST_DRD;
            end
        end else if (gnt_i) begin
            cnt_load = 1'b1;
            state_d  = ST_IRD;
        end else if (arb_pt) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_DSRD && cnt_last) begin
            // Swap write-back follows its read without re-arbitrating.
            cnt_load = 1'b1;
            state_d  = ST_DWR;
        end
    end

    cmc_lat_counter u_lat (
        .clk_i  (i_clk),
        .rst_ni (i_rstn),
        .load_i (cnt_load),
        .val_i  (LOAD_VAL),
        .last_o (cnt_last)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            iack_q   <= 1'b0;
            dack_q   <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
            wbuf_q   <= '0;
`ifdef CORE_MEM_ARB_RR_EN
            last_d_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            iack_q  <= (state_q == ST_IRD) && cnt_last;
            dack_q  <= (state_q == ST_DRD || state_q == ST_DWR) && cnt_last;
            if (state_q == ST_IRD && cnt_last) begin
                irdata_q <= io_memData;
            end
            if ((state_q == ST_DRD || state_q == ST_DSRD) && cnt_last) begin
                drdata_q <= io_memData;
            end
            if (gnt_d) begin
                wbuf_q <= i_dWrData;
            end
`ifdef CORE_MEM_ARB_RR_EN
            if (gnt_d || gnt_i) begin
                last_d_q <= gnt_d;
            end
`endif
        end
    end

    assign o_iAck    = iack_q;
    assign o_dAck    = dack_q;
    assign o_iRdData = irdata_q;
    assign o_dRdData = drdata_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_memWr   = (state_q == ST_DWR);

    // Address is forced to zero while reset is held, independent of the inputs.
    assign o_memAddr = !i_rstn ? '0 :
                       is_data_state(state_q) ? {SEC_DATA, i_dAddr} : {SEC_INSTR, i_iAddr};

    assign io_memData = (state_q == ST_DWR) ? wbuf_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter (MEM_LAT=3 instance).
module tb_core_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int L  = 3;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_iReq;
    logic [AW-1:0] i_iAddr;
    logic          o_iAck;
    logic [DW-1:0] o_iRdData;
    logic          i_dReq;
    logic [AW-1:0] i_dAddr;
    logic          i_dWr;
    logic          i_dSwp;
    logic [DW-1:0] i_dWrData;
    logic          o_dAck;
    logic [DW-1:0] o_dRdData;
    logic          o_busy;
    logic [AW:0]   o_memAddr;
    wire  [DW-1:0] io_memData;
    logic          o_memWr;
    logic [DW-1:0] mem_drv;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    // Memory model: drives read data whenever the arbiter is not writing.
    assign io_memData = o_memWr ? {DW{1'bz}} : mem_drv;

    core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_iReq     (i_iReq),
        .i_iAddr    (i_iAddr),
        .o_iAck     (o_iAck),
        .o_iRdData  (o_iRdData),
        .i_dReq     (i_dReq),
        .i_dAddr    (i_dAddr),
        .i_dWr      (i_dWr),
        .i_dSwp     (i_dSwp),
        .i_dWrData  (i_dWrData),
        .o_dAck     (o_dAck),
        .o_dRdData  (o_dRdData),
        .o_busy     (o_busy),
        .o_memAddr  (o_memAddr),
        .io_memData (io_memData),
        .o_memWr    (o_memWr)
    );

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!o_busy && !o_iAck && !o_dAck) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done) begin failures++; $display("FAIL idle_timeout busy=%b expected 0 within 64 cycles", o_busy); end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_iReq = 1'b0; i_dReq = 1'b0; i_dWr = 1'b0; i_dSwp = 1'b0;
        i_iAddr = 15'h1234; i_dAddr = '0; i_dWrData = '0; mem_drv = '0;
        repeat (2) tick();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_iAck !== 1'b0) begin failures++; $display("FAIL reset_iack got=%b exp=0", o_iAck); end
        checks++; if (o_dAck !== 1'b0) begin failures++; $display("FAIL reset_dack got=%b exp=0", o_dAck); end
        checks++; if (o_iRdData !== 16'h0) begin failures++; $display("FAIL reset_irdata got=%h exp=0000", o_iRdData); end
        checks++; if (o_dRdData !== 16'h0) begin failures++; $display("FAIL reset_drdata got=%h exp=0000", o_dRdData); end
        checks++; if (o_memWr !== 1'b0) begin failures++; $display("FAIL reset_memwr got=%b exp=0", o_memWr); end
        checks++; if (o_memAddr !== 16'h0) begin failures++; $display("FAIL reset_memaddr got=%h exp=0000", o_memAddr); end
        i_iAddr = '0;
        i_rstn  = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        i_iAddr = 15'h0012; mem_drv = 16'hBEEF; i_iReq = 1'b1;
        for (int k = 1; k <= L; k++) begin
            tick();
            checks++; if (o_memAddr !== 16'h0012) begin failures++; $display("FAIL fetch_addr cyc=%0d got=%h exp=0012", k, o_memAddr); end
            checks++; if (o_iAck !== 1'b0) begin failures++; $display("FAIL fetch_early_ack cyc=%0d got=%b exp=0", k, o_iAck); end
            checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL fetch_busy cyc=%0d got=%b exp=1", k, o_busy); end
        end
        tick();
        checks++; if (o_iAck !== 1'b1) begin failures++; $display("FAIL fetch_ack got=%b exp=1", o_iAck); end
        checks++; if (o_iRdData !== 16'hBEEF) begin failures++; $display("FAIL fetch_data got=%h exp=beef", o_iRdData); end
        i_iReq = 1'b0;
        wait_idle();
    endtask

    task automatic test_write();
        i_dAddr = 15'h0040; i_dWrData = 16'h1234; i_dWr = 1'b1; i_dSwp = 1'b0; i_dReq = 1'b1;
        for (int k = 1; k <= L; k++) begin
            tick();
            checks++; if (o_memWr !== 1'b1) begin failures++; $display("FAIL write_memwr cyc=%0d got=%b exp=1", k, o_memWr); end
            checks++; if (o_memAddr !== 16'h8040) begin failures++; $display("FAIL write_addr cyc=%0d got=%h exp=8040", k, o_memAddr); end
            checks++; if (io_memData !== 16'h1234) begin failures++; $display("FAIL write_bus cyc=%0d got=%h exp=1234", k, io_memData); end
            checks++; if (o_dAck !== 1'b0) begin failures++; $display("FAIL write_early_ack cyc=%0d got=%b exp=0", k, o_dAck); end
        end
        tick();
        checks++; if (o_dAck !== 1'b1) begin failures++; $display("FAIL write_ack got=%b exp=1", o_dAck); end
        i_dReq = 1'b0; i_dWr = 1'b0;
        wait_idle();
    endtask

    task automatic test_swap();
        logic exp_wr;
        i_dAddr = 15'h0005; i_dWrData = 16'hAAAA; i_dSwp = 1'b1; i_dWr = 1'b0;
        mem_drv = 16'h5555; i_iAddr = 15'h0077; i_dReq = 1'b1;
        for (int k = 1; k <= 2 * L; k++) begin
            tick();
            if (k == 1) i_iReq = 1'b1;
            exp_wr = (k > L);
            checks++; if (o_memWr !== exp_wr) begin failures++; $display("FAIL swap_phase cyc=%0d memwr=%b exp=%b", k, o_memWr, exp_wr); end
            checks++; if (o_memAddr !== 16'h8005) begin failures++; $display("FAIL swap_addr cyc=%0d got=%h exp=8005", k, o_memAddr); end
            checks++; if (o_dAck !== 1'b0) begin failures++; $display("FAIL swap_early_ack cyc=%0d got=%b exp=0", k, o_dAck); end
            if (exp_wr) begin
                checks++; if (io_memData !== 16'hAAAA) begin failures++; $display("FAIL swap_bus cyc=%0d got=%h exp=aaaa", k, io_memData); end
            end
        end
        tick();
        checks++; if (o_dAck !== 1'b1) begin failures++; $display("FAIL swap_ack got=%b exp=1", o_dAck); end
        checks++; if (o_dRdData !== 16'h5555) begin failures++; $display("FAIL swap_old got=%h exp=5555", o_dRdData); end
        i_dReq = 1'b0; i_iReq = 1'b0; i_dSwp = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic got [4];
        logic exp_d;
        int   cyc [4];
        int   n;
        logic found;
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        i_iAddr = 15'h0011; i_dAddr = 15'h0022; i_dWr = 1'b0; i_dSwp = 1'b0;
        mem_drv = 16'h1357; i_iReq = 1'b1; i_dReq = 1'b1;
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            tick();
            checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL b2b_gap cyc=%0d busy=%b exp=1", c, o_busy); end
            if (o_iAck || o_dAck) begin
                got[n] = o_dAck;
                cyc[n] = c;
                checks++;
                if (o_dAck ? (o_dRdData !== 16'h1357) : (o_iRdData !== 16'h1357)) begin
                    failures++; $display("FAIL b2b_data ack=%0d i=%h d=%h exp=1357", n, o_iRdData, o_dRdData);
                end
                n++;
            end
        end
        checks++; if (n != 4) begin failures++; $display("FAIL b2b_acks got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
`ifdef CORE_MEM_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            checks++; if (got[i] !== exp_d) begin failures++; $display("FAIL b2b_order ack=%0d is_data=%b exp=%b", i, got[i], exp_d); end
            if (i == 0) begin
                checks++; if (cyc[0] != L + 1) begin failures++; $display("FAIL b2b_first cyc=%0d exp=%0d", cyc[0], L + 1); end
            end else begin
                checks++; if (cyc[i] - cyc[i-1] != L) begin failures++; $display("FAIL b2b_spacing ack=%0d gap=%0d exp=%0d", i, cyc[i] - cyc[i-1], L); end
            end
        end
        i_dReq = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 5 * L + 5 && !found; c++) begin
            tick();
            if (o_iAck) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("FAIL b2b_fetch_after_drop got=0 exp=1 within %0d cycles", 5 * L + 5); end
        i_iReq = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid_write();
        i_dAddr = 15'h0033; i_dWrData = 16'h0F0F; i_dWr = 1'b1; i_dSwp = 1'b0;
        mem_drv = 16'h2222; i_dReq = 1'b1;
        tick();
        checks++; if (o_memWr !== 1'b1) begin failures++; $display("FAIL rstmid_started got=%b exp=1", o_memWr); end
        #2 i_rstn = 1'b0;
        #1;
        checks++; if (o_memWr !== 1'b0) begin failures++; $display("FAIL rstmid_memwr got=%b exp=0", o_memWr); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        checks++; if (io_memData !== 16'h2222) begin failures++; $display("FAIL rstmid_bus_released got=%h exp=2222", io_memData); end
        checks++; if (o_memAddr !== 16'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0000", o_memAddr); end
        i_dReq = 1'b0; i_dWr = 1'b0;
        tick();
        checks++; if (o_dAck !== 1'b0) begin failures++; $display("FAIL rstmid_ack_in_reset got=%b exp=0", o_dAck); end
        i_rstn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (o_dAck !== 1'b0) begin failures++; $display("FAIL rstmid_ack_after cyc=%0d got=%b exp=0", k, o_dAck); end
        end
        i_iAddr = 15'h0004; mem_drv = 16'h4444; i_iReq = 1'b1;
        repeat (L + 1) tick();
        checks++; if (o_iAck !== 1'b1) begin failures++; $display("FAIL rstmid_fresh_ack got=%b exp=1", o_iAck); end
        checks++; if (o_iRdData !== 16'h4444) begin failures++; $display("FAIL rstmid_fresh_data got=%h exp=4444", o_iRdData); end
        i_iReq = 1'b0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_swap();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time=%0t exp=finish before 200000", $time);
        $fatal(1);
    end

endmodule
